store_result_monitor: RTL and testbench
=======================================

Name: store_result_monitor

Overview:
- Synthesizable self-check block on the core's data-memory write bus (MemWrite, DataAdr, WriteData) from Top.
- Classifies every store against a pass signature, an allowed scratch address and a cycle timeout.
- Latches a sticky verdict and keeps a small ring trace of recent stores for FPGA/ILA debug.
- Sits beside the data memory as a passive consumer; never stalls the core.

Parameters:
- PASS_ADDR, 100, store address that signals end of program
- PASS_DATA, 25, data value required at PASS_ADDR for a pass
- SCRATCH_ADDR, 96, address where stores are tolerated without a verdict
- TIMEOUT_CYCLES, 1000, cycles after reset release with no verdict before timeout; 0 disables timeout
- TRACE_DEPTH, 4, ring-trace entries (power of two, ≥2)
- CNT_W, 16, width of cycle and store counters

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset
- MemWrite  in  1  core store strobe, valid this cycle
- DataAdr  in  32  store byte address
- WriteData  in  32  store data
- done  out  1  verdict reached (pass|fail|timeout)
- pass  out  1  sticky pass
- fail  out  1  sticky fail
- timeout  out  1  sticky timeout
- store_count  out  CNT_W  stores observed before verdict, saturating
- cycle_count  out  CNT_W  cycles since reset release, frozen at verdict, saturating
- bad_addr  out  32  address of the failing store
- bad_data  out  32  data of the failing store
- trace_idx  in  log2(TRACE_DEPTH)  trace read index (0 = newest)
- trace_addr  out  32  address of entry trace_idx (combinational read)
- trace_data  out  32  data of entry trace_idx

Behaviour:
- Reset (sync, active-high, dominates all other inputs): FSM = RUN; done/pass/fail/timeout = 0; counters = 0; bad_addr/bad_data = 0; trace entries = 0; write pointer = 0. Reset asserted mid-run or after a verdict fully clears.
- FSM states: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal until reset.
- In RUN, at each rising edge with MemWrite=1:
  - DataAdr==PASS_ADDR and WriteData==PASS_DATA → PASS.
  - else DataAdr==SCRATCH_ADDR (any data) → remain RUN.
  - else (including PASS_ADDR with wrong data) → FAIL; capture bad_addr/bad_data.
- Comparisons are full 32-bit equality. X on the bus is not special-cased in RTL.
- MemWrite=1 in RUN: store_count += 1 (saturate at all-ones); push {DataAdr, WriteData} into trace at write pointer; pointer wraps modulo TRACE_DEPTH. The verdict-causing store is counted and traced.
- cycle_count increments every cycle in RUN (saturating), including the verdict cycle; frozen afterwards.
- Timeout: in RUN, if TIMEOUT_CYCLES≠0 and cycle_count == TIMEOUT_CYCLES−1 at the edge with no pass/fail store → TIMEOUT.
- Simultaneous store verdict and timeout in the same cycle: the store verdict wins.
- Outputs are registered; a verdict is visible the cycle after the deciding edge (latency 1). done = pass|fail|timeout, exactly one set.
- Terminal states: MemWrite ignored; counters, trace and bad_* are frozen.
- Trace read: entry = ring[(wptr−1−trace_idx) mod TRACE_DEPTH]. Entries never written read 0.

Decomposition:
- Shared package monitor_pkg holds the state encoding (RUN/PASS/FAIL/TIMEOUT as 2-bit localparams) and the default PASS_ADDR/PASS_DATA/SCRATCH_ADDR constants, so the sim bench and FPGA top agree.
- One sub-module: store_trace_ring (TRACE_DEPTH×64-bit ring with push and indexed newest-relative read).

Test Plan:
- Reset 3 cycles, then stores (96,7), (96,9), (100,25) → pass=1 and done=1 one cycle after the third store; store_count=3; trace_idx 0/1/2 reads (100,25)/(96,9)/(96,7).
- Store (100,24) → fail=1, bad_addr=100, bad_data=24; a later (100,25) leaves pass=0 and store_count=1.
- Store (84,25) → fail=1, bad_addr=84; counters freeze.
- TIMEOUT_CYCLES=20 with no stores → timeout=1 after 20 edges in RUN, cycle_count=20; store (100,25) on edge 20 instead → pass=1, timeout=0.
- After PASS, assert reset for 1 cycle → all outputs 0 and trace reads 0; rerun reaches pass again.
- Six scratch stores with TRACE_DEPTH=4 → pointer wraps; trace_idx 3 returns the 3rd store, not the 1st.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared encodings and default signature constants for the store-result monitor,
// so the simulation bench and the FPGA top agree on what "pass" looks like.
package monitor_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    RUN     = ST_RUN,
    PASS    = ST_PASS,
    FAIL    = ST_FAIL,
    TIMEOUT = ST_TIMEOUT
  } mon_state_t;

  localparam logic [31:0] DEF_PASS_ADDR    = 32'd100;
  localparam logic [31:0] DEF_PASS_DATA    = 32'd25;
  localparam logic [31:0] DEF_SCRATCH_ADDR = 32'd96;

endpackage

// File: rtl/store_trace_ring.sv
// Small ring of recent {address, data} stores with a newest-relative read port
// (rd_idx 0 = most recent push). TRACE_DEPTH must be a power of two.
module store_trace_ring #(
  parameter int TRACE_DEPTH = 4,
  localparam int IDX_W = $clog2(TRACE_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [31:0]      push_addr,
  input  logic [31:0]      push_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_addr,
  output logic [31:0]      rd_data
);

  logic [63:0]      ring [TRACE_DEPTH];
  logic [IDX_W-1:0] wptr;
  logic [IDX_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) ring[i] <= '0;
    end else if (push) begin
      ring[wptr] <= {push_addr, push_data};
      wptr       <= wptr + IDX_W'(1);
    end
  end

  // Pointer arithmetic wraps naturally because the depth is a power of two.
  assign rd_ptr             = wptr - IDX_W'(1) - rd_idx;
  assign {rd_addr, rd_data} = ring[rd_ptr];

endmodule

// File: rtl/store_result_monitor.sv
// Passive watcher on the data-memory write bus: decides pass/fail/timeout from the
// stores a test program makes, and keeps counters plus a short store trace for ILA debug.
module store_result_monitor
  import monitor_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
  parameter logic [31:0] SCRATCH_ADDR   = DEF_SCRATCH_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int          TRACE_DEPTH    = 4,
  parameter int          CNT_W          = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           MemWrite,
  input  logic [31:0]                    DataAdr,
  input  logic [31:0]                    WriteData,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic                           timeout,
  output logic [CNT_W-1:0]               store_count,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [31:0]                    bad_addr,
  output logic [31:0]                    bad_data,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [31:0]                    trace_addr,
  output logic [31:0]                    trace_data
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  mon_state_t state, next_state;
  logic       running;
  logic       store;
  logic       is_pass_store;
  logic       is_scratch_store;
  logic       timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign running          = (state == RUN);
  assign store            = running && MemWrite;
  assign is_pass_store    = (DataAdr == PASS_ADDR) && (WriteData == PASS_DATA);
  assign is_scratch_store = (DataAdr == SCRATCH_ADDR);
  assign timeout_hit      = (TIMEOUT_CYCLES != 0) && (32'(cycle_count) == TMO_LAST);

  // A deciding store takes priority over a timeout landing on the same edge.
  always_comb begin
    next_state = state;
    if (running) begin
      if (MemWrite && is_pass_store)         next_state = PASS;
      else if (MemWrite && !is_scratch_store) next_state = FAIL;
      else if (timeout_hit)                   next_state = TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      store_count <= '0;
      cycle_count <= '0;
      bad_addr    <= '0;
      bad_data    <= '0;
    end else begin
      state <= next_state;
      if (running) cycle_count <= sat_inc(cycle_count);
      if (store)   store_count <= sat_inc(store_count);
      if (running && next_state == FAIL) begin
        bad_addr <= DataAdr;
        bad_data <= WriteData;
      end
    end
  end

  assign pass    = (state == PASS);
  assign fail    = (state == FAIL);
  assign timeout = (state == TIMEOUT);
  assign done    = !running;

  store_trace_ring #(
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .reset     (reset),
    .push      (store),
    .push_addr (DataAdr),
    .push_data (WriteData),
    .rd_idx    (trace_idx),
    .rd_addr   (trace_addr),
    .rd_data   (trace_data)
  );

endmodule

// File: tb/tb_store_result_monitor.sv
// Randomized bench for store_result_monitor: three configurations share one stimulus
// stream and are compared against a verdict/shift-register model every cycle.
module tb_store_result_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData;
  logic [1:0]  tidx0, tidx1;
  logic [0:0]  tidx2;

  logic        o_done [3], o_pass [3], o_fail [3], o_tmo [3];
  logic [15:0] sc0, sc1, cc0, cc1;
  logic [2:0]  sc2, cc2;
  logic [31:0] o_ba [3], o_bd [3], o_ta [3], o_td [3];
  logic [15:0] o_sc [3], o_cc [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  store_result_monitor u_dut0 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .done(o_done[0]), .pass(o_pass[0]), .fail(o_fail[0]), .timeout(o_tmo[0]),
    .store_count(sc0), .cycle_count(cc0), .bad_addr(o_ba[0]), .bad_data(o_bd[0]),
    .trace_idx(tidx0), .trace_addr(o_ta[0]), .trace_data(o_td[0]));

  store_result_monitor #(.TIMEOUT_CYCLES(20)) u_dut1 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .done(o_done[1]), .pass(o_pass[1]), .fail(o_fail[1]), .timeout(o_tmo[1]),
    .store_count(sc1), .cycle_count(cc1), .bad_addr(o_ba[1]), .bad_data(o_bd[1]),
    .trace_idx(tidx1), .trace_addr(o_ta[1]), .trace_data(o_td[1]));

  store_result_monitor #(.TIMEOUT_CYCLES(0), .TRACE_DEPTH(2), .CNT_W(3)) u_dut2 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .done(o_done[2]), .pass(o_pass[2]), .fail(o_fail[2]), .timeout(o_tmo[2]),
    .store_count(sc2), .cycle_count(cc2), .bad_addr(o_ba[2]), .bad_data(o_bd[2]),
    .trace_idx(tidx2), .trace_addr(o_ta[2]), .trace_data(o_td[2]));

  assign o_sc[0] = sc0;
  assign o_sc[1] = sc1;
  assign o_sc[2] = {13'd0, sc2};
  assign o_cc[0] = cc0;
  assign o_cc[1] = cc1;
  assign o_cc[2] = {13'd0, cc2};

  // Reference model: verdict 0 none, 1 pass, 2 fail, 3 timeout; trace[0] is newest.
  int          tmo  [3] = '{1000, 20, 0};
  longint      cmax [3] = '{65535, 65535, 7};
  int          dep  [3] = '{4, 4, 2};
  int          mv   [3];
  longint      msc  [3], mcc [3];
  logic [31:0] mba  [3], mbd [3];
  logic [63:0] mtr  [3][4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic m, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        mv[k] = 0; msc[k] = 0; mcc[k] = 0; mba[k] = 0; mbd[k] = 0;
        for (int j = 0; j < 4; j++) mtr[k][j] = '0;
      end else if (mv[k] == 0) begin
        longint prev = mcc[k];
        if (mcc[k] < cmax[k]) mcc[k]++;
        if (m) begin
          if (msc[k] < cmax[k]) msc[k]++;
          for (int j = dep[k] - 1; j > 0; j--) mtr[k][j] = mtr[k][j-1];
          mtr[k][0] = {a, d};
          if (a == 32'd100 && d == 32'd25) mv[k] = 1;
          else if (a != 32'd96) begin
            mv[k] = 2; mba[k] = a; mbd[k] = d;
          end
        end
        if (mv[k] == 0 && tmo[k] != 0 && prev == longint'(tmo[k] - 1)) mv[k] = 3;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("i%0d.done", k),    64'(o_done[k]), 64'(mv[k] != 0));
      check_eq($sformatf("i%0d.pass", k),    64'(o_pass[k]), 64'(mv[k] == 1));
      check_eq($sformatf("i%0d.fail", k),    64'(o_fail[k]), 64'(mv[k] == 2));
      check_eq($sformatf("i%0d.timeout", k), 64'(o_tmo[k]),  64'(mv[k] == 3));
      check_eq($sformatf("i%0d.store_count", k), 64'(o_sc[k]), 64'(msc[k]));
      check_eq($sformatf("i%0d.cycle_count", k), 64'(o_cc[k]), 64'(mcc[k]));
      check_eq($sformatf("i%0d.bad_addr", k), 64'(o_ba[k]), 64'(mba[k]));
      check_eq($sformatf("i%0d.bad_data", k), 64'(o_bd[k]), 64'(mbd[k]));
    end
    for (int i = 0; i < 4; i++) begin
      tidx0 = 2'(i);
      tidx1 = 2'(i);
      tidx2 = 1'(i);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (i < dep[k]) begin
          check_eq($sformatf("i%0d.trace%0d", k, i), {o_ta[k], o_td[k]}, mtr[k][i]);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic m, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    reset = r; MemWrite = m; DataAdr = a; WriteData = d;
    @(posedge clk);
    model_edge(r, m, a, d);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    tidx0 = '0; tidx1 = '0; tidx2 = '0;
    for (int k = 0; k < 3; k++) mv[k] = 0;

    // Pass sequence after scratch stores.
    do_reset(3);
    step(1'b0, 1'b1, 32'd96, 32'd7);
    step(1'b0, 1'b1, 32'd96, 32'd9);
    step(1'b0, 1'b1, 32'd100, 32'd25);
    idle(2);
    // Reset after pass fully clears, then rerun to pass.
    do_reset(1);
    step(1'b0, 1'b1, 32'd100, 32'd25);

    // Wrong data at the pass address, later correct store ignored.
    do_reset(1);
    step(1'b0, 1'b1, 32'd100, 32'd24);
    step(1'b0, 1'b1, 32'd100, 32'd25);
    idle(2);

    // Store to a disallowed address.
    do_reset(1);
    step(1'b0, 1'b1, 32'd84, 32'd25);
    idle(3);

    // Idle run: the 20-cycle instance times out.
    do_reset(1);
    idle(22);

    // Pass store on the timeout edge wins.
    do_reset(1);
    idle(19);
    step(1'b0, 1'b1, 32'd100, 32'd25);
    idle(2);

    // Ring wrap with six scratch stores; also saturates the narrow counters.
    do_reset(1);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 32'd96, 32'(i));
    for (int i = 7; i <= 10; i++) step(1'b0, 1'b1, 32'd96, 32'(i));

    // Randomized traffic biased toward scratch stores to keep runs alive.
    do_reset(1);
    for (int n = 0; n < 2500; n++) begin
      logic        r, m;
      logic [31:0] a, d;
      int          sel;
      r   = ($urandom_range(0, 59) == 0);
      m   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 11);
      d   = $urandom;
      case (sel)
        0:       begin a = 32'd100; if ($urandom_range(0, 1) == 1) d = 32'd25; end
        1:       a = $urandom;
        2:       a = 32'd84;
        default: a = 32'd96;
      endcase
      step(r, m, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
